// File: rtl/core_pkg.sv
// Shared constants for the core pipeline: load funct3 encodings,
// default datapath width and the hard-wired zero register index.
package core_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int REG_AW_DEFAULT = 5;

    localparam int unsigned REG_ZERO = 0;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/mem_wb_stage_load_fmt.sv
// Load formatter: picks the addressed byte/half/word lane out of a
// full-width read word, extends it, and flags misaligned accesses.
module load_fmt
    import core_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int OFF_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  data,
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] off,
    output logic [XLEN-1:0]  result,
    output logic             misalign
);

    localparam int NB = XLEN/8;
    localparam int NH = XLEN/16;

    logic [7:0]  byte_lane [NB];
    logic [15:0] half_lane [NH];
    logic [7:0]  b_sel;
    logic [15:0] h_sel;
    logic [31:0] w_sel;
    logic [XLEN-1:0] w_sx;
    logic [XLEN-1:0] w_zx;

    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        assign byte_lane[gi] = data[gi*8 +: 8];
    end

    for (genvar gi = 0; gi < NH; gi++) begin : g_half
        assign half_lane[gi] = data[gi*16 +: 16];
    end

    assign b_sel = byte_lane[off];
    assign h_sel = half_lane[off[OFF_W-1:1]];

    // On a 32-bit bus the word lane is the whole bus, so LW/LWU/LD coincide.
    if (XLEN == 64) begin : g_w64
        assign w_sel = off[2] ? data[63:32] : data[31:0];
        assign w_sx  = {{32{w_sel[31]}}, w_sel};
        assign w_zx  = {32'b0, w_sel};
    end else begin : g_w32
        assign w_sel = data[31:0];
        assign w_sx  = w_sel;
        assign w_zx  = w_sel;
    end

    always_comb begin
        result   = data;
        misalign = 1'b0;
        case (funct3)
            F3_LB: begin
                result = {{(XLEN-8){b_sel[7]}}, b_sel};
            end
            F3_LBU: begin
                result = {{(XLEN-8){1'b0}}, b_sel};
            end
            F3_LH: begin
                result   = {{(XLEN-16){h_sel[15]}}, h_sel};
                misalign = off[0];
            end
            F3_LHU: begin
                result   = {{(XLEN-16){1'b0}}, h_sel};
                misalign = off[0];
            end
            F3_LW: begin
                result   = w_sx;
                misalign = |off[1:0];
            end
            F3_LWU: begin
                result   = w_zx;
                misalign = |off[1:0];
            end
            F3_LD: begin
                // At XLEN=32 off is only two bits wide, so this is the LW check.
                result   = data;
                misalign = |off;
            end
            default: begin
                result   = data;
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: valid/ready handshake with flush, captures
// synchronous RAM read data on first occupancy and formats loads for WB.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int OFF_W  = $clog2(XLEN/8)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_wr,
    input  logic              in_mem2reg,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   ram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic              fwd_we,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [XLEN-1:0]   fwd_data,
    output logic              ld_misalign
);

    logic              valid_reg;
    logic              valid_next;
    logic              fresh_reg;
    logic              reg_wr_reg;
    logic              mem2reg_reg;
    logic [2:0]        funct3_reg;
    logic [XLEN-1:0]   alu_reg;
    logic [REG_AW-1:0] rd_reg;
    logic [XLEN-1:0]   hold_reg;

    logic              accept;
    logic              retire;
    logic              rd_live;
    logic [XLEN-1:0]   load_src;
    logic [XLEN-1:0]   load_data;
    logic              fmt_misalign;

    assign in_ready = !valid_reg || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign retire   = valid_reg && out_ready;

    always_comb begin
        valid_next = valid_reg;
        if (flush) begin
            valid_next = 1'b0;
        end else if (accept) begin
            valid_next = 1'b1;
        end else if (retire) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_reg   <= 1'b0;
            fresh_reg   <= 1'b0;
            reg_wr_reg  <= 1'b0;
            mem2reg_reg <= 1'b0;
            funct3_reg  <= '0;
            alu_reg     <= '0;
            rd_reg      <= '0;
            hold_reg    <= '0;
        end else begin
            valid_reg <= valid_next;
            fresh_reg <= accept;
            // RAM data is only valid in the first occupancy cycle; keep it for stalls.
            if (fresh_reg) begin
                hold_reg <= ram_rdata;
            end
            if (accept) begin
                reg_wr_reg  <= in_reg_wr;
                mem2reg_reg <= in_mem2reg;
                funct3_reg  <= in_funct3;
                alu_reg     <= in_alu_result;
                rd_reg      <= in_rd;
            end
        end
    end

    assign load_src = fresh_reg ? ram_rdata : hold_reg;

    load_fmt #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_fmt (
        .data     (load_src),
        .funct3   (funct3_reg),
        .off      (alu_reg[OFF_W-1:0]),
        .result   (load_data),
        .misalign (fmt_misalign)
    );

    assign rd_live     = reg_wr_reg && (rd_reg != REG_AW'(REG_ZERO));
    assign out_valid   = valid_reg;
    assign wb_we       = valid_reg && out_ready && rd_live;
    assign wb_addr     = rd_reg;
    assign wb_data     = mem2reg_reg ? load_data : alu_reg;
    // Forwarding must see the occupant even while WB is stalled.
    assign fwd_we      = valid_reg && rd_live;
    assign fwd_addr    = rd_reg;
    assign fwd_data    = wb_data;
    assign ld_misalign = valid_reg && mem2reg_reg && fmt_misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed test-plan steps followed by a randomized run checked against
// an occupancy-level reference model of the MEM/WB stage.
module tb_mem_wb_stage;
    import core_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rstn;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_reg_wr;
    logic              in_mem2reg;
    logic [2:0]        in_funct3;
    logic [XLEN-1:0]   in_alu_result;
    logic [REG_AW-1:0] in_rd;
    logic [XLEN-1:0]   ram_rdata;
    logic              out_valid;
    logic              out_ready;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              fwd_we;
    logic [REG_AW-1:0] fwd_addr;
    logic [XLEN-1:0]   fwd_data;
    logic              ld_misalign;

    int n_checks = 0;
    int n_pass   = 0;

    mem_wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_wr     (in_reg_wr),
        .in_mem2reg    (in_mem2reg),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_rd         (in_rd),
        .ram_rdata     (ram_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .fwd_we        (fwd_we),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
        .ld_misalign   (ld_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input logic m2r, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [4:0] rd);
        in_valid      = v;
        in_reg_wr     = wr;
        in_mem2reg    = m2r;
        in_funct3     = f3;
        in_alu_result = alu;
        in_rd         = rd;
    endtask

    // Reference load formatting from the ISA rules, 32-bit datapath.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] addr);
        int unsigned off = addr % 4;
        int unsigned b   = (w >> (8 * off)) & 32'hFF;
        int unsigned h   = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic ref_misalign(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned off = addr % 4;
        case (f3)
            3'b001, 3'b101:         return (off % 2) != 0;
            3'b010, 3'b011, 3'b110: return off != 0;
            3'b111:                 return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    logic [2:0]  ext_f3   [4] = '{F3_LB, F3_LBU, F3_LH, F3_LHU};
    logic [31:0] ext_addr [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] ext_exp  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    logic [4:0]  b2b_rd   [4] = '{5'd1, 5'd2, 5'd3, 5'd0};
    logic [31:0] b2b_alu  [4] = '{32'h111, 32'h222, 32'h333, 32'h444};

    // Reference model state: the single occupant of the stage.
    logic        m_valid, m_first, m_wr, m_m2r;
    logic [2:0]  m_f3;
    logic [31:0] m_alu, m_data;
    logic [4:0]  m_rd;

    initial begin
        logic acc;
        logic e_we;
        logic [31:0] e_data;

        rstn = 1'b0; flush = 1'b0; out_ready = 1'b0; ram_rdata = '0;
        drive(0, 0, 0, 3'b000, 32'h0, 5'd0);
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_fwd_we", fwd_we, 0);
        chk("rst_misalign", ld_misalign, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        rstn = 1'b1;

        // Basic load
        tick();
        drive(1, 1, 1, F3_LW, 32'h100, 5'd5);
        out_ready = 1'b1;
        #2 chk("basic_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; ram_rdata = 32'hDEADBEEF;
        #2;
        chk("basic_out_valid", out_valid, 1);
        chk("basic_wb_we", wb_we, 1);
        chk("basic_wb_addr", wb_addr, 5);
        chk("basic_wb_data", wb_data, 32'hDEADBEEF);
        $display("txn basic LW rd=%0d data=%0h", wb_addr, wb_data);
        tick();
        #2 chk("basic_retired", out_valid, 0);

        // Extension table
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(1, 1, 1, ext_f3[i], ext_addr[i], 5'd7);
            tick();
            in_valid = 1'b0; ram_rdata = 32'h80FF7F01;
            #2;
            chk($sformatf("ext%0d_data", i), wb_data, ext_exp[i]);
            chk($sformatf("ext%0d_misalign", i), ld_misalign, 0);
            $display("txn ext f3=%0d addr=%0h data=%0h", ext_f3[i], ext_addr[i], wb_data);
        end
        tick();

        // Stall hold
        tick();
        drive(1, 1, 1, F3_LW, 32'h200, 5'd9);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0; ram_rdata = 32'hAABBCCDD;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("stall%0d_data", c), wb_data, 32'hAABBCCDD);
            chk($sformatf("stall%0d_fwd_we", c), fwd_we, 1);
            chk($sformatf("stall%0d_fwd_data", c), fwd_data, 32'hAABBCCDD);
            chk($sformatf("stall%0d_wb_we", c), wb_we, 0);
            chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
            tick();
            ram_rdata = 32'h12345678;
        end
        out_ready = 1'b1;
        #2;
        chk("stall_release_we", wb_we, 1);
        chk("stall_release_data", wb_data, 32'hAABBCCDD);
        $display("txn stall-release rd=%0d data=%0h", wb_addr, wb_data);
        tick();
        #2 chk("stall_single_write", wb_we, 0);

        // Back-to-back ALU ops
        for (int k = 0; k <= 4; k++) begin
            tick();
            if (k < 4) drive(1, 1, 0, F3_LW, b2b_alu[k], b2b_rd[k]);
            else in_valid = 1'b0;
            #2;
            if (k > 0) begin
                chk($sformatf("b2b%0d_valid", k), out_valid, 1);
                chk($sformatf("b2b%0d_we", k), wb_we, b2b_rd[k-1] != 5'd0);
                chk($sformatf("b2b%0d_addr", k), wb_addr, b2b_rd[k-1]);
                chk($sformatf("b2b%0d_data", k), wb_data, b2b_alu[k-1]);
                $display("txn b2b rd=%0d we=%0d data=%0h", wb_addr, wb_we, wb_data);
            end
        end
        tick();
        #2 chk("b2b_drained", out_valid, 0);

        // Flush with an incoming instruction
        tick();
        drive(1, 1, 1, F3_LW, 32'h300, 5'd10);
        out_ready = 1'b0;
        tick();
        drive(1, 1, 0, F3_LW, 32'h304, 5'd11);
        flush = 1'b1;
        #2 chk("flush1_no_we", wb_we, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #2;
        chk("flush1_valid", out_valid, 0);
        chk("flush1_we", wb_we, 0);
        chk("flush1_fwd_we", fwd_we, 0);
        tick();
        #2 chk("flush1_later_we", wb_we, 0);
        $display("txn flush with in_valid");

        // Flush with no incoming instruction
        tick();
        drive(1, 1, 0, F3_LW, 32'h55, 5'd12);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        #2 chk("flush2_pre_valid", out_valid, 1);
        tick();
        flush = 1'b0; out_ready = 1'b1;
        #2;
        chk("flush2_valid", out_valid, 0);
        chk("flush2_we", wb_we, 0);
        $display("txn flush idle");

        // Misaligned half load
        tick();
        drive(1, 1, 1, F3_LH, 32'h101, 5'd3);
        tick();
        in_valid = 1'b0; ram_rdata = 32'h80FF7F01;
        #2;
        chk("mis_flag", ld_misalign, 1);
        chk("mis_data", wb_data, 32'h00007F01);
        chk("mis_we", wb_we, 1);
        $display("txn misaligned LH data=%0h", wb_data);
        tick();

        // Reset in the middle of a stall
        tick();
        drive(1, 1, 1, F3_LW, 32'h400, 5'd4);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0; ram_rdata = 32'hCAFEF00D;
        #2 chk("rst2_pre_valid", out_valid, 1);
        #1 rstn = 1'b0;
        #1;
        chk("rst2_valid", out_valid, 0);
        chk("rst2_fwd_we", fwd_we, 0);
        chk("rst2_wb_we", wb_we, 0);
        chk("rst2_wb_data", wb_data, 0);
        chk("rst2_misalign", ld_misalign, 0);
        chk("rst2_in_ready", in_ready, 1);
        tick();
        rstn = 1'b1; out_ready = 1'b1;
        #2 chk("rst2_post_we", wb_we, 0);
        tick();
        #2 chk("rst2_post_valid", out_valid, 0);
        $display("txn reset mid-stall");

        // Randomized run against the occupancy model
        m_valid = 1'b0; m_first = 1'b0; m_wr = 1'b0; m_m2r = 1'b0;
        m_f3 = '0; m_alu = '0; m_data = '0; m_rd = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 3'($urandom),
                  $urandom, 5'($urandom_range(0, 7)));
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 15) == 0;
            ram_rdata = $urandom;
            #2;
            if (m_valid && m_first) m_data = ram_rdata;
            e_we   = m_valid && out_ready && m_wr && (m_rd != 0);
            e_data = m_m2r ? ref_load(m_data, m_f3, m_alu) : m_alu;
            chk("rnd_out_valid", out_valid, m_valid);
            chk("rnd_in_ready", in_ready, !m_valid || out_ready);
            chk("rnd_wb_we", wb_we, e_we);
            chk("rnd_fwd_we", fwd_we, m_valid && m_wr && (m_rd != 0));
            chk("rnd_misalign", ld_misalign, m_valid && m_m2r && ref_misalign(m_f3, m_alu));
            if (m_valid) begin
                chk("rnd_wb_addr", wb_addr, m_rd);
                chk("rnd_wb_data", wb_data, e_data);
                chk("rnd_fwd_data", fwd_data, e_data);
            end
            if (e_we) $display("txn rnd cyc=%0d rd=%0d data=%0h", cyc, m_rd, e_data);
            acc = in_valid && (!m_valid || out_ready) && !flush;
            if (flush) m_valid = 1'b0;
            else if (acc) m_valid = 1'b1;
            else if (m_valid && out_ready) m_valid = 1'b0;
            m_first = acc;
            if (acc) begin
                m_wr  = in_reg_wr;
                m_m2r = in_mem2reg;
                m_f3  = in_funct3;
                m_alu = in_alu_result;
                m_rd  = in_rd;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline stage with a valid/ready handshake, stall and flush support, and load-data formatting.
- Sits between the data-RAM access stage and the register-file write port.
- Captures synchronous-RAM read data on the first cycle of occupancy and holds it across WB stalls.
- Sign- or zero-extends loads, and drives both the write-back port and an identical forwarding port.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
REG_AW, 5, register-file address width
OFF_W, $clog2(XLEN/8), byte-offset bits taken from alu_result (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
flush  in  1  kill occupant and any incoming transfer
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  stage can accept this cycle
in_reg_wr  in  1  instruction writes rd
in_mem2reg  in  1  1 = write-back value is load data, 0 = ALU result
in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
in_alu_result  in  XLEN  ALU result, which is also the load address
in_rd  in  REG_AW  destination register
ram_rdata  in  XLEN  RAM read data, valid the cycle after acceptance
out_valid  out  1  stage holds a live instruction
out_ready  in  1  WB can retire; 0 = stall
wb_we  out  1  register-file write enable
wb_addr  out  REG_AW  write address
wb_data  out  XLEN  write data
fwd_we / fwd_addr / fwd_data  out  1 / REG_AW / XLEN  forwarding copy of wb_*
ld_misalign  out  1  live load with a misaligned address

Behaviour:
- Reset: asynchronous on rstn low. All registers and outputs go to 0: out_valid, wb_*, fwd_*, ld_misalign, hold register, fresh flag. in_ready = 1.
- in_ready = !out_valid | out_ready. This is combinational, and it does not depend on flush.
- Accept occurs when in_valid & in_ready & !flush. On accept, register the ctrl/funct3/alu_result/rd fields, set out_valid = 1 and fresh = 1. Latency is 1 cycle from accept to out_valid.
- Retire occurs when out_valid & out_ready. With no simultaneous accept, out_valid drops to 0 at the next edge. Retire and accept in the same cycle gives back-to-back occupancy: out_valid stays 1 and fresh is set again.
- flush = 1: out_valid is 0 at the next edge regardless of in_valid or out_ready. The incoming instruction is dropped. wb_we is not suppressed in the flush cycle itself; the controller never flushes a retiring instruction.
- RAM capture:
  - Cycle with fresh = 1: the load source is ram_rdata directly, and ram_rdata is also written into the hold register. fresh clears at the next edge unless a new accept occurs.
  - Cycles with fresh = 0 (stalled): the load source is the hold register. ram_rdata is ignored.
- Load formatting, with off = alu_result[OFF_W-1:0]:
  - Byte loads: select byte lane off.
  - Half loads: select lane off[OFF_W-1:1].
  - Word loads: select lane off[OFF_W-1:2] (XLEN = 64 only; at XLEN = 32 the word is the whole bus).
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD passes the full 64 bits.
  - Low offset bits below the access size are ignored.
  - At XLEN = 32, LD and LWU are treated as LW.
  - funct3 = 111 formats as the full word and asserts ld_misalign.
- ld_misalign = out_valid & mem2reg & (half with off[0] = 1, word with off[1:0] != 0, LD with off != 0, or funct3 = 111). Informational only; it does not block the write.
- wb_data = mem2reg ? formatted load : alu_result.
- wb_we = out_valid & out_ready & reg_wr & (rd != 0). This is combinational.
- wb_addr = rd.
- fwd_* equal wb_* except fwd_we = out_valid & reg_wr & (rd != 0). Forwarding stays active while stalled.
- Reset mid-stall: the occupant is lost, out_valid = 0, and no write occurs after rstn rises.

Decomposition:
- Shared package core_pkg holds:
  - funct3 load encodings (LB..LWU) as localparams;
  - the XLEN default;
  - a REG_ZERO constant.
- Sub-module load_fmt: combinational lane-select plus extension, parametrised by XLEN. Inputs are raw data, funct3 and off; outputs are the formatted data and the misalign flag.
- The handshake, hold register and fresh flag stay in mem_wb_stage.

Test Plan:
- Basic load: accept LW (funct3 010, addr 0x100, rd 5, mem2reg 1), ram_rdata 0xDEADBEEF next cycle, out_ready 1 -> wb_we 1, wb_addr 5, wb_data 0xDEADBEEF, 1 cycle after accept.
- Extension: ram_rdata 0x80FF7F01. LB at addr 0x103 -> 0xFFFFFF80. LBU at addr 0x103 -> 0x00000080. LH at addr 0x102 -> 0xFFFF80FF. LHU at addr 0x100 -> 0x00007F01.
- Stall hold: accept LW, then out_ready 0 for 3 cycles with ram_rdata changed to 0x12345678 after the first cycle -> wb_data stays at the first-cycle value, fwd_we 1, wb_we 0, in_ready 0. Raising out_ready gives a single write.
- Back-to-back: ALU ops to rd 1, 2, 3 on consecutive cycles with out_ready 1 -> three consecutive writes with the matching rd and alu_result. rd 0 instruction -> wb_we 0.
- Flush: flush with in_valid 1 while occupied and stalled -> out_valid 0 next edge and no write ever issued for either instruction. Flush with in_valid 0 -> same.
- Misalign/reset: LH at addr 0x101 -> ld_misalign 1, data is half-lane 0. rstn low mid-stall -> all outputs 0 immediately (async), in_ready 1.
